// File: rtl/asic_cmdq_pkg.sv
// Shared types and constants for the accelerator command queue.
// Optional same-cycle bypass path is enabled by defining ASIC_CMDQ_BYPASS_EN.
package asic_cmdq_pkg;

    // One buffered processor command as seen by the accelerator.
    typedef struct packed {
        logic [63:0] rs1;
        logic [6:0]  funct;
        logic [6:0]  opcode;
    } asic_cmd_t;

    localparam int ASIC_CMD_NBITS = 78;

    // custom-0 opcode space
    localparam logic [6:0] ASIC_ACCEL_OPCODE_DEFAULT = 7'h0B;

    // True when a command targets the accelerator and must be buffered.
    function automatic logic is_accel_cmd(input asic_cmd_t cmd, input logic [6:0] accel_opcode);
        return (cmd.opcode == accel_opcode);
    endfunction

endpackage

// File: rtl/asic_cmd_queue_if.sv
// Handshake bundle between processor, command queue and accelerator.
// master = processor/accelerator side, slave = the queue itself.
interface asic_cmd_queue_if;

    // processor -> queue
    logic [63:0] cmd_rs1_i;
    logic [6:0]  cmd_inst_funct_i;
    logic [6:0]  cmd_inst_opcode_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;

    // queue -> accelerator
    logic [63:0] deq_rs1_o;
    logic [6:0]  deq_inst_funct_o;
    logic [6:0]  deq_inst_opcode_o;
    logic        deq_valid_o;
    logic        deq_ready_i;

    modport master (
        output cmd_rs1_i, cmd_inst_funct_i, cmd_inst_opcode_i, cmd_valid_i, deq_ready_i,
        input  cmd_ready_o, deq_rs1_o, deq_inst_funct_o, deq_inst_opcode_o, deq_valid_o
    );

    modport slave (
        input  cmd_rs1_i, cmd_inst_funct_i, cmd_inst_opcode_i, cmd_valid_i, deq_ready_i,
        output cmd_ready_o, deq_rs1_o, deq_inst_funct_o, deq_inst_opcode_o, deq_valid_o
    );

endinterface

// File: rtl/asic_cmdq_storage.sv
// DEPTH-entry command register array: one write port, one asynchronous read port.
// Contents are intentionally not reset; validity is tracked by the pointers.
module asic_cmdq_storage
    import asic_cmdq_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  asic_cmd_t       wr_data,
    input  logic [AW-1:0]   rd_addr,
    output asic_cmd_t       rd_data
);

    asic_cmd_t mem_reg [DEPTH];

    // Capture the incoming command into the addressed entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    // Head entry is read combinationally so the queue can present it without extra latency.
    assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/asic_cmd_queue.sv
// Decoupling command FIFO in front of the accelerator command port.
// Filters non-accelerator opcodes (counted as drops) and buffers the rest in order.
// Define ASIC_CMDQ_BYPASS_EN to let a matching command reach an empty queue's
// output in the same cycle; otherwise the path is strictly registered.
module asic_cmd_queue
    import asic_cmdq_pkg::*;
#(
    parameter int         DEPTH         = 4,
    parameter logic [6:0] ACCEL_OPCODE  = ASIC_ACCEL_OPCODE_DEFAULT,
    parameter int         DROP_CNT_BITS = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    asic_cmd_queue_if.slave           bus,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      drop_pulse_o,
    output logic [DROP_CNT_BITS-1:0]  drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0]            wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]            rd_ptr_reg, rd_ptr_next;
    logic [DROP_CNT_BITS-1:0] drop_cnt_reg, drop_cnt_next;
    logic                     drop_pulse_reg;

    asic_cmd_t cmd_in;
    asic_cmd_t head;

    logic empty;
    logic full;
    logic cmd_match;
    logic enq_fire;
    logic drop_fire;
    logic bypass_hit;
    logic wr_en;
    logic rd_adv;

    assign cmd_in = '{rs1: bus.cmd_rs1_i, funct: bus.cmd_inst_funct_i, opcode: bus.cmd_inst_opcode_i};

    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign full      = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) && (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign cmd_match = is_accel_cmd(cmd_in, ACCEL_OPCODE);

    // Ready depends only on occupancy, never on the accelerator's ready.
    assign bus.cmd_ready_o = !full;
    assign enq_fire        = bus.cmd_valid_i && !full;
    assign drop_fire       = enq_fire && !cmd_match;

    // Output selection: head entry, or the live command when bypassing an empty queue.
    always_comb begin
        bypass_hit            = 1'b0;
        bus.deq_valid_o       = !empty;
        bus.deq_rs1_o         = head.rs1;
        bus.deq_inst_funct_o  = head.funct;
        bus.deq_inst_opcode_o = head.opcode;
`ifdef ASIC_CMDQ_BYPASS_EN
        bypass_hit = empty && bus.cmd_valid_i && cmd_match;
        if (empty) begin
            bus.deq_valid_o       = bypass_hit;
            bus.deq_rs1_o         = cmd_in.rs1;
            bus.deq_inst_funct_o  = cmd_in.funct;
            bus.deq_inst_opcode_o = cmd_in.opcode;
        end
`endif
    end

    // A bypassed command consumed this cycle is never written to storage.
    assign wr_en  = enq_fire && cmd_match && !(bypass_hit && bus.deq_ready_i);
    assign rd_adv = bus.deq_ready_i && !empty;

    // Next-state for pointers and the saturating drop counter.
    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        drop_cnt_next = drop_cnt_reg;
        if (wr_en) begin
            wr_ptr_next = wr_ptr_reg + PW'(1);
        end
        if (rd_adv) begin
            rd_ptr_next = rd_ptr_reg + PW'(1);
        end
        if (drop_fire && (drop_cnt_reg != {DROP_CNT_BITS{1'b1}})) begin
            drop_cnt_next = drop_cnt_reg + DROP_CNT_BITS'(1);
        end
    end

    // Control state; cleared immediately by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            drop_cnt_reg   <= '0;
            drop_pulse_reg <= 1'b0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            drop_cnt_reg   <= drop_cnt_next;
            drop_pulse_reg <= drop_fire;
        end
    end

    asic_cmdq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_reg[AW-1:0]),
        .wr_data (cmd_in),
        .rd_addr (rd_ptr_reg[AW-1:0]),
        .rd_data (head)
    );

    assign count_o      = wr_ptr_reg - rd_ptr_reg;
    assign drop_pulse_o = drop_pulse_reg;
    assign drop_cnt_o   = drop_cnt_reg;

endmodule

// File: tb/tb_asic_cmd_queue.sv
// Directed bench for asic_cmd_queue (DEPTH=4, DROP_CNT_BITS=2).
// Bypass expectations are selected with ASIC_CMDQ_BYPASS_EN.
module tb_asic_cmd_queue;
    import asic_cmdq_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] count_o;
    logic       drop_pulse_o;
    logic [1:0] drop_cnt_o;

    int checks   = 0;
    int failures = 0;

    asic_cmd_queue_if bus ();

    asic_cmd_queue #(
        .DEPTH         (4),
        .ACCEL_OPCODE  (7'h0B),
        .DROP_CNT_BITS (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .count_o      (count_o),
        .drop_pulse_o (drop_pulse_o),
        .drop_cnt_o   (drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] rs1, input logic [6:0] funct, input logic [6:0] opc);
        bus.cmd_valid_i       = v;
        bus.cmd_rs1_i         = rs1;
        bus.cmd_inst_funct_i  = funct;
        bus.cmd_inst_opcode_i = opc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        bus.deq_ready_i = 1'b0;
        drive(1'b0, 64'h0, 7'h0, 7'h0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_deq_valid", {63'b0, bus.deq_valid_o}, 64'd0);
        chk("rst_cmd_ready", {63'b0, bus.cmd_ready_o}, 64'd1);
        chk("rst_count", {61'b0, count_o}, 64'd0);
        chk("rst_drop_cnt", {62'b0, drop_cnt_o}, 64'd0);
        chk("rst_drop_pulse", {63'b0, drop_pulse_o}, 64'd0);

`ifdef ASIC_CMDQ_BYPASS_EN
        // Bypass: empty queue, accelerator ready -> same-cycle delivery, nothing stored.
        bus.deq_ready_i = 1'b1;
        drive(1'b1, 64'h55, 7'd2, 7'h0B);
        #1;
        chk("byp_deq_valid", {63'b0, bus.deq_valid_o}, 64'd1);
        chk("byp_deq_rs1", bus.deq_rs1_o, 64'h55);
        chk("byp_count", {61'b0, count_o}, 64'd0);
        tick();
        drive(1'b0, 64'h0, 7'h0, 7'h0);
        #1;
        chk("byp_count_after", {61'b0, count_o}, 64'd0);
        chk("byp_deq_valid_after", {63'b0, bus.deq_valid_o}, 64'd0);
`else
        // Single command round trip with one-cycle latency.
        bus.deq_ready_i = 1'b1;
        drive(1'b1, 64'h1234, 7'd3, 7'h0B);
        #1;
        chk("t1_deq_valid_same_cycle", {63'b0, bus.deq_valid_o}, 64'd0);
        tick();
        drive(1'b0, 64'h0, 7'h0, 7'h0);
        chk("t1_deq_valid", {63'b0, bus.deq_valid_o}, 64'd1);
        chk("t1_rs1", bus.deq_rs1_o, 64'h1234);
        chk("t1_funct", {57'b0, bus.deq_inst_funct_o}, 64'd3);
        chk("t1_opcode", {57'b0, bus.deq_inst_opcode_o}, 64'h0B);
        chk("t1_count", {61'b0, count_o}, 64'd1);
        tick();
        chk("t1_count_end", {61'b0, count_o}, 64'd0);
        chk("t1_deq_valid_end", {63'b0, bus.deq_valid_o}, 64'd0);
`endif

        // Back-pressure: fill four, fifth waits until space frees.
        bus.deq_ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 64'(i), 7'd0, 7'h0B);
            tick();
        end
        drive(1'b1, 64'd5, 7'd0, 7'h0B);
        #1;
        chk("bp_full_ready", {63'b0, bus.cmd_ready_o}, 64'd0);
        chk("bp_full_count", {61'b0, count_o}, 64'd4);
        chk("bp_hold_rs1", bus.deq_rs1_o, 64'd1);
        tick();
        chk("bp_still_full", {61'b0, count_o}, 64'd4);
        chk("bp_hold_rs1_2", bus.deq_rs1_o, 64'd1);
        bus.deq_ready_i = 1'b1;
        #1;
        chk("bp_head1", bus.deq_rs1_o, 64'd1);
        chk("bp_refuse", {63'b0, bus.cmd_ready_o}, 64'd0);
        tick();
        chk("bp_head2", bus.deq_rs1_o, 64'd2);
        chk("bp_ready_again", {63'b0, bus.cmd_ready_o}, 64'd1);
        chk("bp_count3", {61'b0, count_o}, 64'd3);
        tick();
        drive(1'b0, 64'h0, 7'h0, 7'h0);
        chk("bp_count_simul", {61'b0, count_o}, 64'd3);
        chk("bp_head3", bus.deq_rs1_o, 64'd3);
        tick();
        chk("bp_head4", bus.deq_rs1_o, 64'd4);
        tick();
        chk("bp_head5", bus.deq_rs1_o, 64'd5);
        chk("bp_count1", {61'b0, count_o}, 64'd1);
        tick();
        chk("bp_empty", {63'b0, bus.deq_valid_o}, 64'd0);
        chk("bp_count0", {61'b0, count_o}, 64'd0);

        // Streaming: prime one entry, then enqueue and dequeue together for 20 cycles.
        bus.deq_ready_i = 1'b0;
        drive(1'b1, 64'd100, 7'd0, 7'h0B);
        tick();
        bus.deq_ready_i = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, 64'(100 + i), 7'(i), 7'h0B);
            #1;
            chk($sformatf("st_head_%0d", i), bus.deq_rs1_o, 64'(100 + i - 1));
            chk($sformatf("st_count_%0d", i), {61'b0, count_o}, 64'd1);
            tick();
        end
        drive(1'b0, 64'h0, 7'h0, 7'h0);
        chk("st_last", bus.deq_rs1_o, 64'd120);
        chk("st_last_funct", {57'b0, bus.deq_inst_funct_o}, 64'd20);
        tick();
        chk("st_drained", {61'b0, count_o}, 64'd0);

        // Filtering: non-matching opcode is accepted, never dequeued, and counted.
        drive(1'b1, 64'hDEAD, 7'd1, 7'h33);
        #1;
        chk("flt_ready", {63'b0, bus.cmd_ready_o}, 64'd1);
        chk("flt_no_deq", {63'b0, bus.deq_valid_o}, 64'd0);
        tick();
        drive(1'b0, 64'h0, 7'h0, 7'h0);
        chk("flt_pulse", {63'b0, drop_pulse_o}, 64'd1);
        chk("flt_cnt1", {62'b0, drop_cnt_o}, 64'd1);
        chk("flt_deq_valid", {63'b0, bus.deq_valid_o}, 64'd0);
        chk("flt_count", {61'b0, count_o}, 64'd0);
        tick();
        chk("flt_pulse_clear", {63'b0, drop_pulse_o}, 64'd0);
        drive(1'b1, 64'hBEEF, 7'd1, 7'h33);
        tick();
        chk("flt_cnt2", {62'b0, drop_cnt_o}, 64'd2);
        tick();
        chk("flt_cnt3", {62'b0, drop_cnt_o}, 64'd3);
        tick();
        chk("flt_sat4", {62'b0, drop_cnt_o}, 64'd3);
        tick();
        chk("flt_sat5", {62'b0, drop_cnt_o}, 64'd3);
        chk("flt_pulse_sat", {63'b0, drop_pulse_o}, 64'd1);
        drive(1'b0, 64'h0, 7'h0, 7'h0);
        tick();
        chk("flt_pulse_end", {63'b0, drop_pulse_o}, 64'd0);
        chk("flt_never_deq", {63'b0, bus.deq_valid_o}, 64'd0);

        // Asynchronous reset mid-cycle with three entries buffered.
        bus.deq_ready_i = 1'b0;
        for (int i = 7; i <= 9; i++) begin
            drive(1'b1, 64'(i), 7'd0, 7'h0B);
            tick();
        end
        drive(1'b0, 64'h0, 7'h0, 7'h0);
        chk("ar_count3", {61'b0, count_o}, 64'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_deq_valid", {63'b0, bus.deq_valid_o}, 64'd0);
        chk("ar_count", {61'b0, count_o}, 64'd0);
        chk("ar_drop_cnt", {62'b0, drop_cnt_o}, 64'd0);
        reset = 1'b0;
        #1;
        chk("ar_cmd_ready", {63'b0, bus.cmd_ready_o}, 64'd1);
        tick();
        drive(1'b1, 64'hABC, 7'd4, 7'h0B);
        tick();
        drive(1'b0, 64'h0, 7'h0, 7'h0);
        chk("ar_push_valid", {63'b0, bus.deq_valid_o}, 64'd1);
        chk("ar_push_rs1", bus.deq_rs1_o, 64'hABC);
        chk("ar_push_count", {61'b0, count_o}, 64'd1);
        bus.deq_ready_i = 1'b1;
        tick();
        chk("ar_pop_count", {61'b0, count_o}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/asic_cmd_queue.md
Name: asic_cmd_queue

Overview:
- Decoupling command FIFO placed directly upstream of the accelerator's command port. It sits between the processor command source and the accelerator.
- Accepts processor commands (rs1, funct, opcode) on a valid/ready handshake, filters out commands whose opcode does not target the accelerator, and buffers the rest.
- Presents buffered commands in order to the accelerator's cmd_valid/cmd_ready interface.
- Exposes occupancy and a saturating dropped-command count for tracing and debug.

Parameters:
- DEPTH, 4, number of buffered command entries; power of 2, minimum 2.
- ACCEL_OPCODE, 7'h0B, opcode value that identifies commands for the accelerator (custom-0).
- DROP_CNT_BITS, 8, width of the saturating dropped-command counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_rs1_i  in  64  processor command operand.
- cmd_inst_funct_i  in  7  processor command funct field.
- cmd_inst_opcode_i  in  7  processor command opcode field.
- cmd_valid_i  in  1  processor command valid.
- cmd_ready_o  out  1  queue can accept a command.
- deq_rs1_o  out  64  head-entry operand, to the accelerator's cmd_rs1_i.
- deq_inst_funct_o  out  7  head-entry funct, to the accelerator's cmd_inst_funct_i.
- deq_inst_opcode_o  out  7  head-entry opcode, to the accelerator's cmd_inst_opcode_i.
- deq_valid_o  out  1  head entry valid, to the accelerator's cmd_valid_i.
- deq_ready_i  in  1  from the accelerator's cmd_ready_o.
- count_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- drop_pulse_o  out  1  one-cycle pulse when a non-matching command is discarded.
- drop_cnt_o  out  DROP_CNT_BITS  saturating count of discarded commands.

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately, mid-transfer included):
  - Pointers, count_o, drop_cnt_o and drop_pulse_o clear to 0.
  - deq_valid_o=0 and cmd_ready_o=1 once reset deasserts.
  - Storage contents are not reset. deq_* data outputs are don't-care while deq_valid_o=0.
- Storage and status:
  - Circular buffer with read and write pointers of $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty = pointers equal. full = index bits equal and wrap bits differ.
- Enqueue fire = cmd_valid_i & cmd_ready_o.
  - cmd_ready_o = !full. It does not depend on deq_ready_i, so there is no combinational ready path.
  - If opcode == ACCEL_OPCODE: write {rs1, funct, opcode} at the write pointer, then increment the write pointer.
  - Otherwise: the command is accepted but not stored. drop_pulse_o=1 the next cycle, and drop_cnt_o increments, saturating at all-ones.
- Dequeue fire = deq_valid_o & deq_ready_i.
  - deq_valid_o = !empty. deq_* are driven combinationally from the head entry (registered storage).
  - The read pointer increments on fire.
- Latency: an entry written in cycle N is visible on deq_valid_o in cycle N+1 (without the optional feature).
- Simultaneous enqueue and dequeue: both fire and count_o is unchanged.
  - When full, enqueue is refused even if a dequeue fires that cycle.
  - When empty, no dequeue occurs that cycle.
- Pointer wrap-around: index bits wrap modulo DEPTH; the wrap bit toggles on each wrap.
- A dropped command while full: not possible, because cmd_ready_o=0 gates all acceptance, filtered commands included.
- Data outputs hold stable while deq_valid_o=1 and deq_ready_i=0.

Optional Feature:
- Macro ASIC_CMDQ_BYPASS_EN.
- Defined:
  - When the queue is empty and the incoming command matches ACCEL_OPCODE, it is presented on deq_* in the same cycle (deq_valid_o = cmd_valid_i & opcode match).
  - If deq_ready_i=1 that cycle, the command is consumed without being written and the pointers do not move. Otherwise it is written normally.
  - This creates a combinational path from cmd_* to deq_*.
- Undefined: strictly registered one-cycle latency, no combinational cmd-to-deq path.

Decomposition:
- Package asic_cmdq_pkg:
  - typedef struct packed asic_cmd_t {logic [63:0] rs1; logic [6:0] funct; logic [6:0] opcode;}.
  - localparam ASIC_CMD_NBITS = 78.
  - Default ACCEL_OPCODE constant.
- One sub-module: asic_cmdq_storage, a DEPTH x asic_cmd_t register array with one write port and one asynchronous read port.
- Pointer, full/empty, filter and drop-counter logic live in the top.

Test Plan:
- Single command, opcode 0x0B, rs1=0x1234, funct=3, deq_ready_i=1 -> deq_valid_o rises the cycle after acceptance with the same fields; count_o returns to 0.
- Back-pressure: deq_ready_i=0, DEPTH=4, push 5 matching commands -> cmd_ready_o=0 after the 4th, count_o=4. Then release deq_ready_i -> FIFO order rs1=1,2,3,4 followed by 5.
- Continuous enqueue and dequeue for 20 commands -> count_o stays 1 in steady state, no loss or reordering across multiple pointer wraps.
- Filtering: opcode 0x33 command -> accepted, never appears on deq, drop_pulse_o one cycle, drop_cnt_o=1. With DROP_CNT_BITS=2 and 5 drops -> drop_cnt_o saturates at 3.
- Asynchronous reset asserted mid-cycle with count_o=3 -> deq_valid_o=0 and count_o=0 immediately, without waiting for a clock edge. After release the next push round-trips correctly.
- With ASIC_CMDQ_BYPASS_EN, empty queue, deq_ready_i=1, matching command -> deq_valid_o=1 in the same cycle and count_o stays 0.
